// File: rtl/slave_rr_arbiter.sv
// slave_rr_arbiter: per-slave round-robin arbiter with grant hold-until-ack,
// abort on request drop, and an optional watchdog on stuck transactions.
module slave_rr_arbiter #(
  parameter int QTY_OF_MASTERS = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [QTY_OF_MASTERS-1:0]         request_from_masters,
  input  logic                              slave_ack,
  output logic [QTY_OF_MASTERS-1:0]         grant_to_masters,
  output logic                              grant_valid,
  output logic [$clog2(QTY_OF_MASTERS)-1:0] granted_master_id,
  output logic                              timeout_pulse
);

  localparam int IDX_W = $clog2(QTY_OF_MASTERS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                    state_q;
  logic [QTY_OF_MASTERS-1:0] grant_q;
  logic                      valid_q;
  logic [IDX_W-1:0]          id_q;
  logic                      timeout_q;
  logic [IDX_W-1:0]          ptr_q;

  // Requests rotated so that bit 0 is the master currently holding top priority.
  logic [QTY_OF_MASTERS-1:0] rot_req;
  logic [IDX_W-1:0]          pick_off;
  logic                      pick_found;
  logic [IDX_W-1:0]          pick_idx;
  logic                      wd_expire;
  logic                      owner_req;

  generate
    for (genvar gi = 0; gi < QTY_OF_MASTERS; gi++) begin : g_rot
      assign rot_req[gi] = request_from_masters[ptr_q + IDX_W'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the next winner; offset maps back via the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int k = 0; k < QTY_OF_MASTERS; k++) begin
      if (!pick_found && rot_req[k]) begin
        pick_found = 1'b1;
        pick_off   = IDX_W'(k);
      end
    end
  end

  assign pick_idx  = ptr_q + pick_off;
  assign owner_req = request_from_masters[id_q];

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CNT_W-1:0] wd_cnt_q;

      // Counts BUSY cycles; held at zero in IDLE so every grant starts from zero.
      always_ff @(posedge clk) begin
        if (rst || state_q != BUSY) begin
          wd_cnt_q <= '0;
        end else begin
          wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
      end

      assign wd_expire = (state_q == BUSY) && (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
      assign wd_expire = 1'b0;
    end
  endgenerate

  // Arbitration FSM; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q <= QTY_OF_MASTERS'(1) << pick_idx;
            valid_q <= 1'b1;
            id_q    <= pick_idx;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // Ack wins over abort and over expiry; abort also suppresses the timeout pulse.
          if (slave_ack || !owner_req || wd_expire) begin
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= id_q + IDX_W'(1);
            state_q   <= IDLE;
            timeout_q <= !slave_ack && owner_req;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_to_masters  = grant_q;
  assign grant_valid       = valid_q;
  assign granted_master_id = id_q;
  assign timeout_pulse     = timeout_q;

endmodule
